counter_seq_ctrl: RTL

Command-driven sequencer for the 4-bit counting datapath. It accepts a (start, end) command over a valid/ready handshake, loads the count register, and advances it once every PRESCALE clocks until the end value is reached. It then pulses `done` and returns to idle. The block sits between the control logic that issues count jobs and the `dout` consumers, and adds pause and abort control.

---
 rtl/counter_seq_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - command-driven count sequencer with prescaler, pause and abort
//
// Accepts a (start, end) job over a valid/ready handshake, loads the count
// register with start, and advances it once every PRESCALE clocks until it
// reaches end. Then it pulses done for one cycle and returns to idle.
//
// Optional feature macro: COUNTER_SEQ_CTRL_DOWN_EN
//   defined   : adds the cmd_dir port; dir=1 counts down (wrapping 0 -> max)
//   undefined : up-count only, no cmd_dir port, no down-count logic
//
// Parameters:
//   WIDTH     count register width, arithmetic modulo 2^WIDTH
//   PRESCALE  clocks per count step, 1..255
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   cmd_valid  command offered
//   cmd_ready  command can be accepted (IDLE and not in reset)
//   cmd_start  first count value
//   cmd_end    terminal count value
//   cmd_dir    count direction, 1 = down (COUNTER_SEQ_CTRL_DOWN_EN only)
//   pause      level; freezes count and prescaler
//   abort      level; ends the job without done
//   dout       current count, registered
//   busy       job in progress (RUN or HOLD)
//   done       one-cycle pulse at job completion

module counter_seq_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_end,
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
    input  logic             cmd_dir,
`endif
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0]       PSC_LAST = 8'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic [WIDTH-1:0] end_q;
    logic [WIDTH-1:0] end_nxt;
    logic [7:0]       psc;
    logic [7:0]       psc_nxt;
    logic [WIDTH-1:0] step_val;
    logic             advance;

`ifdef COUNTER_SEQ_CTRL_DOWN_EN
    logic dir_q;
    logic dir_nxt;

    assign step_val = dir_q ? (dout - ONE) : (dout + ONE);
`else
    assign step_val = dout + ONE;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            dout  <= '0;
            psc   <= '0;
            end_q <= '0;
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
            dir_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            dout  <= dout_nxt;
            psc   <= psc_nxt;
            end_q <= end_nxt;
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
            dir_q <= dir_nxt;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        dout_nxt  = dout;
        psc_nxt   = psc;
        end_nxt   = end_q;
        advance   = 1'b0;
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
        dir_nxt   = dir_q;
`endif

        case (state)
            S_IDLE: begin
                // cmd_ready is just (state==IDLE) outside reset, and reset
                // overrides the register update, so cmd_valid alone suffices.
                if (cmd_valid) begin
                    dout_nxt  = cmd_start;
                    end_nxt   = cmd_end;
                    psc_nxt   = '0;
                    state_nxt = S_RUN;
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
                    dir_nxt   = cmd_dir;
`endif
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (pause) begin
                    state_nxt = S_HOLD;
                end else begin
                    advance = 1'b1;
                end
            end
            S_HOLD: begin
                // Leaving HOLD also performs that cycle's count step, so each
                // cycle with pause sampled high costs exactly one clock.
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (!pause) begin
                    advance = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (advance) begin
            state_nxt = S_RUN;
            if (psc == PSC_LAST) begin
                psc_nxt = '0;
                // The end value is held for one full step before completing,
                // giving ((end-start) mod 2^WIDTH)+1 steps per job.
                if (dout == end_q) begin
                    state_nxt = S_DONE;
                end else begin
                    dout_nxt = step_val;
                end
            end else begin
                psc_nxt = psc + 8'd1;
            end
        end
    end

    // Outputs decoded from registered state
    assign cmd_ready = (state == S_IDLE) && !reset;
    assign busy      = (state == S_RUN) || (state == S_HOLD);
    assign done      = (state == S_DONE);

endmodule
